audio_envelope: RTL and testbench
=================================

AUDIO_ENVELOPE -- requirements
Module: audio_envelope

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 Port clk: input, 1 bit, system clock; all state SHALL be updated on the rising edge of clk.
REQ-003 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-004 Port vsync: input, 1 bit, frame pulse; only its rising edge SHALL be used, detected against a registered copy.
REQ-005 Port audio_in: input, 1 bit, raw square-wave tone from the sound generator, synchronous to clk.
REQ-006 Port vol_up: input, 1 bit, single-cycle pulse that raises the volume.
REQ-007 Port vol_down: input, 1 bit, single-cycle pulse that lowers the volume.
REQ-008 Port mute: input, 1 bit, level signal that silences the output.
REQ-009 Port audio_out: output, 1 bit, enveloped and PWM-attenuated audio.
REQ-010 Port level: output, 4 bits, current effective amplitude.

Function
REQ-011 Volume register vol (4 bits) SHALL change as follows:
- vol_up alone: +1, saturating at 15.
- vol_down alone: -1, saturating at 0.
- Both asserted in the same cycle: no change.
REQ-012 An audio edge SHALL be defined as audio_in differing from its registered copy a_q.
REQ-013 The state machine SHALL have states IDLE, SUSTAIN and DECAY.
REQ-014 Envelope env (4 bits) and hold counter hold (2 bits) SHALL be updated in every state by these rules:
- Audio edge: state becomes SUSTAIN, env <= vol, hold <= 0.
- Audio edge and vsync rise in the same cycle: the edge rule SHALL take priority and the vsync rise SHALL be ignored.
REQ-015 In SUSTAIN, env SHALL track vol every cycle, so a volume change is visible on the next cycle.
REQ-016 In SUSTAIN, each vsync rise without an audio edge SHALL increment hold; when hold reaches HOLD_FRAMES (2), the state SHALL become DECAY and env SHALL keep its value.
REQ-017 In DECAY, each vsync rise without an audio edge SHALL decrement env by 1; if env is 0 or 1 before the decrement, env SHALL become 0 and the state SHALL become IDLE.
REQ-018 In IDLE, env SHALL be 0 and hold SHALL be 0.
REQ-019 A free-running 4-bit counter pwm_cnt SHALL increment every cycle and wrap from 15 to 0.
REQ-020 On every clock, audio_out SHALL be registered as audio_in AND (pwm_cnt < env) AND NOT mute, using the register values of the current cycle; latency is 1 cycle.
REQ-021 When env is 0, audio_out SHALL be constant 0; when env is 15, the output duty SHALL be 15/16 while audio_in is high.
REQ-022 level SHALL be combinational: 0 when mute is high, otherwise env.
REQ-023 mute SHALL NOT affect state, env, hold or vol.

Reset
REQ-024 While rst_n is low, the block SHALL hold the following values asynchronously:
- state = IDLE, env = 0, hold = 0, pwm_cnt = 0.
- vol = VOL_RESET (8).
- a_q = 0, audio_out = 0.
- Registered vsync copy = 0.
REQ-025 Reset asserted in the middle of SUSTAIN or DECAY SHALL abort the envelope; after release the block SHALL wait in IDLE for the next audio edge.
REQ-026 A vsync that is already high when rst_n is released SHALL NOT count as a rising edge in the first cycle after release.

Structure
REQ-027 The shared common package SHALL hold:
- The state enum (IDLE/SUSTAIN/DECAY).
- HOLD_FRAMES = 2.
- VOL_RESET = 8.
- The 4-bit width constant ENV_W.
REQ-028 The PWM comparator and pwm_cnt SHALL be a sub-module pwm4 with inputs clk, rst_n and duty[3:0], and output on; audio_envelope SHALL AND its output with audio_in and NOT mute.
REQ-029 The module SHALL be placed directly downstream of the sound generator, with audio_out driving the top-level audio pin.

Verification
REQ-030 Reset release, audio_in toggling every 64 cycles: state = SUSTAIN and env = 8 after the first edge; audio_out is high during 8 of every 16 cycles while audio_in is high.
REQ-031 SUSTAIN, edges stopped, vsync pulses applied: state = DECAY after the 2nd rise; env = 7, 6, … on later rises; IDLE with env = 0 after the 10th rise; audio_out stays 0 from then on.
REQ-032 DECAY with env = 3, audio edge in the same cycle as a vsync rise: next cycle shows state = SUSTAIN, env = vol (8), hold = 0, with no decrement.
REQ-033 Volume saturation: 10 vol_up pulses from reset give vol = 15; 20 vol_down pulses give vol = 0; simultaneous up+down leaves vol unchanged; env in SUSTAIN tracks each step one cycle later.
REQ-034 mute asserted during SUSTAIN with env = 8: audio_out = 0 and level = 0; after deassert, level = 8 and the PWM resumes with unchanged phase.
REQ-035 rst_n pulsed low during DECAY with env = 5: audio_out = 0 and env = 0 immediately; vol returns to 8; with vsync held high across release, no decrement occurs.

Source files
------------

// File: rtl/audio_envelope_pkg.sv
// Shared definitions for the audio envelope block.
//   ENV_W       : width of the volume, envelope and PWM duty values
//   HOLD_FRAMES : frames a tone sustains after its last edge before decaying
//   VOL_RESET   : volume after reset
//   env_state_e : envelope state machine encoding
package audio_envelope_pkg;

    localparam int unsigned ENV_W       = 4;
    localparam int unsigned HOLD_FRAMES = 2;

    localparam logic [ENV_W-1:0] VOL_RESET = ENV_W'(8);

    typedef enum logic [1:0] {
        StIdle,
        StSustain,
        StDecay
    } env_state_e;

endpackage

// File: rtl/audio_envelope_pwm4.sv
// 4-bit PWM generator.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   duty  : on-time in sixteenths of the PWM period
//   on    : high while the free-running counter is below duty
module pwm4
    import audio_envelope_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ENV_W-1:0] duty,
    output logic             on
);

    logic [ENV_W-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + ENV_W'(1);  // wraps 15 -> 0
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // duty 0 never turns on, duty 15 gives 15/16.
    assign on = (pwm_cnt_q < duty);

endmodule

// File: rtl/audio_envelope.sv
// Volume-controlled envelope and PWM attenuator for a square-wave tone.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   vsync     : frame pulse, rising edge advances hold/decay
//   audio_in  : raw square-wave tone
//   vol_up    : single-cycle volume increment
//   vol_down  : single-cycle volume decrement
//   mute      : level-sensitive output silence
//   audio_out : enveloped, PWM-attenuated audio (registered)
//   level     : current effective amplitude (0 while muted)
module audio_envelope
    import audio_envelope_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             audio_in,
    input  logic             vol_up,
    input  logic             vol_down,
    input  logic             mute,
    output logic             audio_out,
    output logic [ENV_W-1:0] level
);

    localparam logic [1:0] HoldLast = 2'(HOLD_FRAMES);

    env_state_e       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [ENV_W-1:0] vol_q, vol_d;
    logic [1:0]       hold_q, hold_d;
    logic             a_q, vs_q, armed_q;
    logic             audio_out_d;
    logic             audio_edge, vs_rise, pwm_on;
    logic [1:0]       hold_inc;

    assign audio_edge = audio_in ^ a_q;
    // armed_q masks the first cycle after reset so a vsync already high at
    // release is not mistaken for a rising edge.
    assign vs_rise    = vsync & ~vs_q & armed_q;
    assign hold_inc   = hold_q + 2'd1;

    always_comb begin
        vol_d = vol_q;
        unique case ({vol_up, vol_down})
            2'b10:   if (vol_q != '1) vol_d = vol_q + ENV_W'(1);
            2'b01:   if (vol_q != '0) vol_d = vol_q - ENV_W'(1);
            default: vol_d = vol_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        hold_d  = hold_q;
        if (audio_edge) begin
            // A new edge restarts the envelope and wins over a same-cycle vsync.
            state_d = StSustain;
            env_d   = vol_q;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    env_d  = '0;
                    hold_d = '0;
                end
                StSustain: begin
                    env_d = vol_q;
                    if (vs_rise) begin
                        hold_d = hold_inc;
                        if (hold_inc == HoldLast) begin
                            state_d = StDecay;
                            env_d   = env_q;
                        end
                    end
                end
                StDecay: begin
                    if (vs_rise) begin
                        if (env_q <= ENV_W'(1)) begin
                            env_d   = '0;
                            state_d = StIdle;
                        end else begin
                            env_d = env_q - ENV_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    env_d   = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    pwm4 u_pwm4 (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (env_q),
        .on    (pwm_on)
    );

    assign audio_out_d = audio_in & pwm_on & ~mute;
    assign level       = mute ? '0 : env_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            env_q     <= '0;
            hold_q    <= '0;
            vol_q     <= VOL_RESET;
            a_q       <= 1'b0;
            vs_q      <= 1'b0;
            armed_q   <= 1'b0;
            audio_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            env_q     <= env_d;
            hold_q    <= hold_d;
            vol_q     <= vol_d;
            a_q       <= audio_in;
            vs_q      <= vsync;
            armed_q   <= 1'b1;
            audio_out <= audio_out_d;
        end
    end

endmodule

// File: tb/tb_audio_envelope.sv
module tb_audio_envelope;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync, audio_in, vol_up, vol_down, mute;
    logic       audio_out;
    logic [3:0] level;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: amplitude envelope described by mode and frame counts.
    // mode 0 = silent, 1 = holding at volume, 2 = fading one step per frame.
    int m_mode, m_env, m_vol, m_frames, m_phase, m_out;
    int m_prev_audio, m_prev_vs, m_live;

    always #5 clk = ~clk;

    audio_envelope dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .audio_in  (audio_in),
        .vol_up    (vol_up),
        .vol_down  (vol_down),
        .mute      (mute),
        .audio_out (audio_out),
        .level     (level)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_env = 0; m_vol = 8; m_frames = 0; m_phase = 0; m_out = 0;
        m_prev_audio = 0; m_prev_vs = 0; m_live = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit tone_edge, frame;
        int new_vol;
        tone_edge = (int'(audio_in) != m_prev_audio);
        frame     = vsync && (m_prev_vs == 0) && (m_live != 0);
        m_out     = (audio_in && (m_phase < m_env) && !mute) ? 1 : 0;
        new_vol = m_vol;
        if (vol_up && !vol_down)      new_vol = (m_vol == 15) ? 15 : m_vol + 1;
        else if (vol_down && !vol_up) new_vol = (m_vol == 0) ? 0 : m_vol - 1;
        if (tone_edge) begin
            m_mode = 1; m_env = m_vol; m_frames = 0;
        end else if (m_mode == 1) begin
            if (frame) m_frames++;
            if (m_frames >= 2) m_mode = 2;  // env frozen at last sustained value
            else m_env = m_vol;
        end else if (m_mode == 2) begin
            if (frame) begin
                m_env = (m_env > 1) ? m_env - 1 : 0;
                if (m_env == 0) m_mode = 0;
            end
        end else begin
            m_env = 0; m_frames = 0;
        end
        m_vol        = new_vol;
        m_phase      = (m_phase + 1) % 16;
        m_prev_audio = audio_in;
        m_prev_vs    = vsync;
        m_live       = 1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            check_eq("audio_out", audio_out, m_out);
            check_eq("level", level, mute ? 0 : m_env);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_audio_out", audio_out, 0);
        check_eq("rst_level", level, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic frame_pulse();
        vsync = 1'b1; cyc(1);
        vsync = 1'b0; cyc(2);
    endtask

    task automatic vol_pulse(input bit up, input bit dn);
        vol_up = up; vol_down = dn; cyc(1);
        vol_up = 1'b0; vol_down = 1'b0; cyc(1);
    endtask

    initial begin
        int ones;
        rst_n = 1'b0; vsync = 1'b0; audio_in = 1'b0;
        vol_up = 1'b0; vol_down = 1'b0; mute = 1'b0;
        apply_reset();
        cyc(3);
        check_eq("idle_level", level, 0);

        // Tone toggling every 64 cycles: sustain at 8, half duty.
        audio_in = 1'b1; cyc(1);
        check_eq("first_edge_level", level, 8);
        cyc(15);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            ones += audio_out;
        end
        check_eq("duty_8_of_16", ones, 8);
        cyc(32);
        for (int k = 0; k < 3; k++) begin
            audio_in = ~audio_in; cyc(64);
        end

        // Frames with no edges: hold two, then fade to silence.
        for (int r = 1; r <= 10; r++) begin
            frame_pulse();
            if (r == 2)  check_eq("decay_entry_level", level, 8);
            if (r == 3)  check_eq("decay_first_step", level, 7);
            if (r == 10) check_eq("decay_done_level", level, 0);
        end
        audio_in = 1'b0;
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            ones += audio_out;
        end
        check_eq("silent_after_decay", ones, 0);

        // Edge coinciding with a frame in decay at env 3 restarts sustain.
        audio_in = 1'b1; cyc(2);
        for (int r = 0; r < 7; r++) frame_pulse();
        check_eq("decay_env3", level, 3);
        vsync = 1'b1; audio_in = 1'b0; cyc(1);
        check_eq("edge_beats_frame", level, 8);
        vsync = 1'b0; cyc(4);
        check_eq("no_late_decrement", level, 8);

        // Volume saturation with env tracking in sustain.
        apply_reset();
        for (int i = 0; i < 10; i++) vol_pulse(1'b1, 1'b0);
        audio_in = 1'b1; cyc(1);
        check_eq("vol_sat_high", level, 15);
        for (int i = 0; i < 20; i++) begin
            vol_pulse(1'b0, 1'b1);
            check_eq("vol_down_track", level, (14 - i < 0) ? 0 : 14 - i);
        end
        vol_pulse(1'b1, 1'b0);
        vol_pulse(1'b1, 1'b1);
        check_eq("vol_up_down_same", level, 1);

        // Mute during sustain.
        apply_reset();
        audio_in = 1'b1; cyc(4);
        mute = 1'b1; cyc(5);
        check_eq("mute_level", level, 0);
        check_eq("mute_audio_out", audio_out, 0);
        mute = 1'b0; cyc(1);
        check_eq("unmute_level", level, 8);
        cyc(20);

        // Reset in decay at env 5 with vsync held high across release.
        vol_pulse(1'b1, 1'b0);
        audio_in = 1'b0; cyc(1);
        for (int r = 0; r < 6; r++) frame_pulse();
        check_eq("decay_env5", level, 5);
        vsync = 1'b1;
        apply_reset();
        cyc(3);
        vsync = 1'b0; cyc(2);
        audio_in = 1'b1; cyc(1);
        check_eq("vol_back_to_8", level, 8);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(23, 0) == 0) audio_in = ~audio_in;
            vsync    = ($urandom_range(5, 0) == 0) ? ~vsync : vsync;
            vol_up   = ($urandom_range(15, 0) == 0);
            vol_down = ($urandom_range(15, 0) == 0);
            if ($urandom_range(31, 0) == 0) mute = ~mute;
            if ($urandom_range(799, 0) == 0) apply_reset();
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
